hex_digit_counter: RTL



---
 rtl/hex_digit_counter_pkg.sv | 18 +
 rtl/hex_digit_counter_if.sv | 14 +
 rtl/hex_digit_counter_key_debounce.sv | 62 ++++++
 rtl/hex_digit_counter.sv | 109 ++++++++++
 4 files changed

// File: rtl/hex_digit_counter_pkg.sv
// Shared constants and default timing for the hex digit counter.
package hex_digit_counter_pkg;

    localparam int unsigned DIGIT_W = 4;

    // SW[8] direction encoding
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // KEY bit positions
    localparam int unsigned KEY_STEP = 0;
    localparam int unsigned KEY_LOAD = 1;

    // 10 ms debounce and 1 s auto tick at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEFAULT_TICK_CYCLES     = 50000000;

endpackage

// File: rtl/hex_digit_counter_if.sv
// Board-side bundle: switches and keys in, digit and status out.
interface hex_digit_counter_if;
    import hex_digit_counter_pkg::*;

    logic [9:0]         SW;
    logic [1:0]         KEY;
    logic [DIGIT_W-1:0] DIGIT;
    logic               WRAP;
    logic               AUTO_ON;

    modport master (output SW, KEY, input DIGIT, WRAP, AUTO_ON);
    modport slave  (input SW, KEY, output DIGIT, WRAP, AUTO_ON);

endinterface

// File: rtl/hex_digit_counter_key_debounce.sv
// One pushbutton: 2-FF synchroniser, debounce counter, accepted level, press pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1, sync2;
    logic             level_c;
    logic             accepted_q, accepted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Raw key is active-low; idle (released) is 1 out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign level_c = ~sync2;

    // Count consecutive disagreeing cycles; accept on the DEBOUNCE_CYCLES-th
    always_comb begin
        cnt_d      = '0;
        accepted_d = accepted_q;
        press_d    = 1'b0;
        if (level_c != accepted_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                accepted_d = level_c;
                press_d    = level_c;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            accepted_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/hex_digit_counter.sv
// 4-bit hex digit source for the seven-segment decoder: step, load, auto tick.
module hex_digit_counter
    import hex_digit_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_CYCLES     = DEFAULT_TICK_CYCLES
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    hex_digit_counter_if.slave  bus
);

    localparam int unsigned PRE_W = $clog2(TICK_CYCLES);

    logic [DIGIT_W-1:0] sw_val_s1, sw_val_s2;
    logic [1:0]         sw_ctl_s1, sw_ctl_s2;
    logic               dir_c, auto_c;
    logic               step_press, load_press;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic               tick_c;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               wrap_q, wrap_d;
    logic               auto_on_q;
    logic               sw_unused;

    assign sw_unused = ^bus.SW[7:4];

    // Switch synchronisers: SW[3:0] load value, SW[9:8] auto/direction
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sw_val_s1 <= '0;
            sw_val_s2 <= '0;
            sw_ctl_s1 <= '0;
            sw_ctl_s2 <= '0;
        end else begin
            sw_val_s1 <= bus.SW[3:0];
            sw_val_s2 <= sw_val_s1;
            sw_ctl_s1 <= bus.SW[9:8];
            sw_ctl_s2 <= sw_ctl_s1;
        end
    end

    assign dir_c  = sw_ctl_s2[0];
    assign auto_c = sw_ctl_s2[1];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .key_n (bus.KEY[KEY_STEP]),
        .press (step_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .key_n (bus.KEY[KEY_LOAD]),
        .press (load_press)
    );

    // Prescaler: 0..TICK_CYCLES-1 while auto, parked at 0 otherwise
    always_comb begin
        presc_d = '0;
        tick_c  = 1'b0;
        if (auto_c) begin
            if (presc_q == PRE_W'(TICK_CYCLES - 1)) begin
                tick_c = 1'b1;
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    // Digit update: load beats step/tick; step and tick together move once
    always_comb begin
        digit_d = digit_q;
        wrap_d  = 1'b0;
        if (load_press) begin
            digit_d = sw_val_s2;
        end else if (step_press || tick_c) begin
            if (dir_c == DIR_DOWN) begin
                digit_d = digit_q - DIGIT_W'(1);
                wrap_d  = (digit_q == '0);
            end else begin
                digit_d = digit_q + DIGIT_W'(1);
                wrap_d  = (digit_q == '1);
            end
        end
    end

    // Output and prescaler registers
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            presc_q   <= '0;
            digit_q   <= '0;
            wrap_q    <= 1'b0;
            auto_on_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            wrap_q    <= wrap_d;
            auto_on_q <= auto_c;
        end
    end

    assign bus.DIGIT   = digit_q;
    assign bus.WRAP    = wrap_q;
    assign bus.AUTO_ON = auto_on_q;

endmodule
